// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-port ALU arbiter: FSM state encoding and
// the default operand/control widths used by alu_arb.
package alu_arb_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CTRW  = 4;

  // One operation walks IDLE -> EXEC -> RESP, so a single port can issue at
  // most one operation every three cycles.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage : alu_arb_pkg

// File: rtl/alu_arb.sv
// Two-requester arbiter in front of a single shared combinational ALU.
// A granted requester's operands are registered onto SrcA/SrcB/ALUCtr, the
// ALU output is captured one cycle later, and the result is presented with
// a one-cycle Done pulse to the owning port. Ties go to the port that did
// not complete the previous operation.
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CTRW  = DEF_CTRW
) (
  input  logic             clk,
  input  logic             rst,
  // requester 0
  input  logic             Req0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [CTRW-1:0]  Ctr0,
  output logic             Ack0,
  output logic             Done0,
  // requester 1
  input  logic             Req1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic [CTRW-1:0]  Ctr1,
  output logic             Ack1,
  output logic             Done1,
  // shared result
  output logic [WIDTH-1:0] Res,
  output logic             ZeroOut,
  // shared ALU interface
  output logic [WIDTH-1:0] SrcA,
  output logic [WIDTH-1:0] SrcB,
  output logic [CTRW-1:0]  ALUCtr,
  input  logic [WIDTH-1:0] ALURes,
  input  logic             Zero,
  output logic             Busy
);

  state_t             r_state;
  state_t             w_state_next;

  logic               r_last;    // port that completed the last operation
  logic               r_owner;   // port whose operation is in flight
  logic [WIDTH-1:0]   r_src_a;
  logic [WIDTH-1:0]   r_src_b;
  logic [CTRW-1:0]    r_alu_ctr;
  logic [WIDTH-1:0]   r_res;
  logic               r_zero;

  logic               w_grant0;
  logic               w_grant1;
  logic               w_grant_any;
  logic               w_done0;
  logic               w_done1;
  logic               w_busy;

  // State register; reset returns to IDLE and abandons any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, round-robin grant and Mealy Ack / Moore Done decode.
  // Everything is forced low while rst is high so no handshake leaks out
  // in the reset cycle itself.
  always_comb begin
    w_state_next = r_state;
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
    w_done0      = 1'b0;
    w_done1      = 1'b0;
    w_busy       = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          // Lone requester always wins; on a tie the port that was not
          // served last goes first.
          w_grant0 = Req0 && (!Req1 || r_last);
          w_grant1 = Req1 && (!Req0 || !r_last);
          if (w_grant0 || w_grant1) begin
            w_state_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          w_busy       = 1'b1;
          w_state_next = ST_RESP;
        end
        ST_RESP: begin
          w_busy       = 1'b1;
          w_done0      = !r_owner;
          w_done1      = r_owner;
          w_state_next = ST_IDLE;
        end
        default: begin
          // Unreachable encoding: recover to IDLE without reporting.
          w_busy       = 1'b1;
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign w_grant_any = w_grant0 | w_grant1;

  // Operand capture on grant, result capture in EXEC, fairness pointer
  // update in RESP; every register holds its value outside its load edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_src_a   <= '0;
      r_src_b   <= '0;
      r_alu_ctr <= '0;
      r_res     <= '0;
      r_zero    <= 1'b0;
    end else begin
      if (w_grant_any) begin
        r_src_a   <= w_grant1 ? A1   : A0;
        r_src_b   <= w_grant1 ? B1   : B0;
        r_alu_ctr <= w_grant1 ? Ctr1 : Ctr0;
        r_owner   <= w_grant1;
      end
      if (r_state == ST_EXEC) begin
        r_res  <= ALURes;
        r_zero <= Zero;
      end
      if (r_state == ST_RESP) begin
        r_last <= r_owner;
      end
    end
  end

  assign Ack0    = w_grant0;
  assign Ack1    = w_grant1;
  assign Done0   = w_done0;
  assign Done1   = w_done1;
  assign Busy    = w_busy;
  assign SrcA    = r_src_a;
  assign SrcB    = r_src_b;
  assign ALUCtr  = r_alu_ctr;
  assign Res     = r_res;
  assign ZeroOut = r_zero;

endmodule : alu_arb

// File: tb/tb_alu_arb.sv
// Directed testbench for alu_arb with a stub ALU (A + B + Ctr, zero flag).
module tb_alu_arb;

  localparam int W = 8;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         Req0, Req1;
  logic [W-1:0] A0, B0, A1, B1;
  logic [C-1:0] Ctr0, Ctr1;
  logic         Ack0, Ack1, Done0, Done1, ZeroOut, Busy, Zero;
  logic [W-1:0] Res, SrcA, SrcB, ALURes;
  logic [C-1:0] ALUCtr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stub ALU sitting beside the arbiter, as the parent would place it.
  assign ALURes = SrcA + SrcB + {4'b0000, ALUCtr};
  assign Zero   = (ALURes == 8'h00);

  alu_arb #(.WIDTH(W), .CTRW(C)) dut (
    .clk(clk), .rst(rst),
    .Req0(Req0), .A0(A0), .B0(B0), .Ctr0(Ctr0), .Ack0(Ack0), .Done0(Done0),
    .Req1(Req1), .A1(A1), .B1(B1), .Ctr1(Ctr1), .Ack1(Ack1), .Done1(Done1),
    .Res(Res), .ZeroOut(ZeroOut),
    .SrcA(SrcA), .SrcB(SrcB), .ALUCtr(ALUCtr),
    .ALURes(ALURes), .Zero(Zero), .Busy(Busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Move to just after the next rising edge (inputs are driven here).
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled on the falling edge.
  task automatic sample();
    @(negedge clk);
  endtask

  // One full operation starting in an IDLE cycle with inputs already set:
  // Ack in this cycle, Busy next, Done with result two cycles later.
  task automatic run_op(input string tag, input logic port,
                        input logic [W-1:0] exp_res, input logic exp_z);
    sample();
    chk({tag, "_ack0"},  32'(Ack0),  32'(port == 1'b0));
    chk({tag, "_ack1"},  32'(Ack1),  32'(port == 1'b1));
    chk({tag, "_idle"},  32'(Busy),  32'(0));
    next_cyc();
    sample();
    chk({tag, "_exec"},  32'(Busy),  32'(1));
    chk({tag, "_noack"}, 32'({Ack1, Ack0}), 32'(0));
    next_cyc();
    sample();
    chk({tag, "_done0"}, 32'(Done0),   32'(port == 1'b0));
    chk({tag, "_done1"}, 32'(Done1),   32'(port == 1'b1));
    chk({tag, "_res"},   32'(Res),     32'(exp_res));
    chk({tag, "_zero"},  32'(ZeroOut), 32'(exp_z));
    next_cyc();
  endtask

  initial begin
    rst = 1'b1;
    Req0 = 1'b1; Req1 = 1'b1;
    A0 = 8'h00; B0 = 8'h00; Ctr0 = 4'h0;
    A1 = 8'h00; B1 = 8'h00; Ctr1 = 4'h0;

    // Reset: all handshakes suppressed even with requests pending.
    next_cyc();
    next_cyc();
    sample();
    chk("rst_ack",  32'({Ack1, Ack0}),   32'(0));
    chk("rst_done", 32'({Done1, Done0}), 32'(0));
    chk("rst_busy", 32'(Busy),           32'(0));
    chk("rst_srca", 32'(SrcA),           32'(0));
    chk("rst_res",  32'(Res),            32'(0));

    // Single op on port 0: F0 + 05 + 1 = F6.
    next_cyc();
    rst = 1'b0; Req1 = 1'b0;
    Req0 = 1'b1; A0 = 8'hF0; B0 = 8'h05; Ctr0 = 4'h1;
    sample();
    chk("c1_ack0", 32'(Ack0), 32'(1));
    chk("c1_ack1", 32'(Ack1), 32'(0));
    next_cyc();
    Req0 = 1'b0; A0 = 8'h00; B0 = 8'h00; Ctr0 = 4'h0;
    sample();
    chk("c2_srca", 32'(SrcA),   32'(8'hF0));
    chk("c2_srcb", 32'(SrcB),   32'(8'h05));
    chk("c2_ctr",  32'(ALUCtr), 32'(4'h1));
    chk("c2_busy", 32'(Busy),   32'(1));
    next_cyc();
    sample();
    chk("c3_done0", 32'(Done0),   32'(1));
    chk("c3_done1", 32'(Done1),   32'(0));
    chk("c3_res",   32'(Res),     32'(8'hF6));
    chk("c3_zero",  32'(ZeroOut), 32'(0));
    chk("c3_srca",  32'(SrcA),    32'(8'hF0));
    next_cyc();

    // Fresh reset, then both ports held: order 0,1,0,1 every 3 cycles.
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    Req0 = 1'b1; A0 = 8'h11; B0 = 8'h01; Ctr0 = 4'h0;
    Req1 = 1'b1; A1 = 8'h22; B1 = 8'h02; Ctr1 = 4'h0;
    run_op("rr_a", 1'b0, 8'h12, 1'b0);
    run_op("rr_b", 1'b1, 8'h24, 1'b0);
    run_op("rr_c", 1'b0, 8'h12, 1'b0);
    run_op("rr_d", 1'b1, 8'h24, 1'b0);
    Req0 = 1'b0; Req1 = 1'b0;

    // Zero flag both ways; port 0 held back-to-back with no idle gap.
    Req0 = 1'b1; A0 = 8'hFB; B0 = 8'h05;
    run_op("z1", 1'b0, 8'h00, 1'b1);
    A0 = 8'hF0; B0 = 8'h0F;
    run_op("z0", 1'b0, 8'hFF, 1'b0);
    Req0 = 1'b0;

    // Port 1 pulses a request during port 0's EXEC only: dropped.
    Req0 = 1'b1; A0 = 8'h01; B0 = 8'h01;
    sample();
    chk("drop_ack0", 32'(Ack0), 32'(1));
    next_cyc();
    Req0 = 1'b0; Req1 = 1'b1; A1 = 8'h77;
    sample();
    chk("drop_exec_ack1", 32'(Ack1), 32'(0));
    next_cyc();
    Req1 = 1'b0;
    sample();
    chk("drop_done0", 32'(Done0), 32'(1));
    chk("drop_res",   32'(Res),   32'(8'h02));
    chk("drop_done1", 32'(Done1), 32'(0));
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      sample();
      chk("drop_quiet", 32'({Ack1, Done1}), 32'(0));
    end

    // Reset during EXEC abandons the op and clears all outputs.
    next_cyc();
    Req0 = 1'b1; A0 = 8'h33; B0 = 8'h01;
    sample();
    chk("abort_ack0", 32'(Ack0), 32'(1));
    next_cyc();
    Req0 = 1'b0; rst = 1'b1;
    sample();
    chk("abort_rbusy", 32'(Busy),           32'(0));
    chk("abort_rdone", 32'({Done1, Done0}), 32'(0));
    next_cyc();
    rst = 1'b0;
    sample();
    chk("abort_busy", 32'(Busy),           32'(0));
    chk("abort_done", 32'({Done1, Done0}), 32'(0));
    chk("abort_srca", 32'(SrcA),           32'(0));
    chk("abort_srcb", 32'(SrcB),           32'(0));
    chk("abort_res",  32'(Res),            32'(0));
    chk("abort_zero", 32'(ZeroOut),        32'(0));
    next_cyc();
    sample();
    chk("abort_late_done", 32'({Done1, Done0}), 32'(0));
    next_cyc();
    Req0 = 1'b1; A0 = 8'h44; B0 = 8'h00;
    Req1 = 1'b1; A1 = 8'h55; B1 = 8'h00;
    run_op("post_rst", 1'b0, 8'h44, 1'b0);
    Req0 = 1'b0; Req1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_alu_arb
